turnstile_gate: RTL
===================

# turnstile_gate

Gate-side controller at the far end of the validator's 3-bit status code. It consumes the code the fare FSM drives toward the seven-segment coder and turns each fresh "fare accepted" event into one barrier opening. It supervises the passage beam, closes the gate on completed passage or timeout, and counts passengers. Optionally, it raises a forced-entry alarm. It is clocked from the same divided clock as the fare FSM.

## Interface
- `OPEN_TICKS`, default 8: cycles the gate stays open waiting for the beam before timing out (≥2).
- `ALARM_TICKS`, default 4: minimum cycles the alarm is held (≥1).
- `CNT_W`, default 8: passenger counter width.
- `clk` in 1: divided system clock; all logic on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `code` in 3: validator status. 3'd1 = FARE_OK; every other value = no grant.
- `beam` in 1: passage sensor; high while a body is in the gate.
- `gate_open` out 1: barrier release.
- `grant_ack` out 1: one-cycle pulse per accepted grant, back to the validator.
- `timeout` out 1: one-cycle pulse when an opening expires unused.
- `alarm` out 1: forced-entry indicator.
- `pass_count` out CNT_W: completed passages, wrapping.
- `state` out 2: 0 CLOSED, 1 OPEN, 2 PASSING, 3 ALARM.

## Operation
- `code_q` registers `code` each cycle.
- A grant edge occurs in a cycle where `code`==3'd1 and `code_q`!=3'd1. A level held at 3'd1 yields exactly one grant.
- On reset, `code_q` loads the current `code`, so a code held at FARE_OK through reset does not grant.
- CLOSED:
  - grant edge → OPEN, timer cleared, `grant_ack` pulses.
  - else `beam`=1 → ALARM (with the macro) or stay (without it).
- OPEN:
  - `beam`=1 → PASSING.
  - else timer reaching OPEN_TICKS-1 → `timeout` pulse, then CLOSED (or OPEN if pending).
  - else timer increments.
- PASSING: on `beam` falling to 0 → `pass_count`+1 (wraps from all-ones to 0), then CLOSED, or OPEN if pending.
- ALARM: timer counts from 0. Exit to CLOSED (or OPEN if pending) when timer ≥ ALARM_TICKS-1 and `beam`=0.
- Pending flag, one deep:
  - A grant edge while in OPEN, PASSING or ALARM sets pending and pulses `grant_ack`.
  - A grant edge while pending is already set is dropped, with no ack.
  - Entering OPEN from pending clears it, reloads the timer and keeps `gate_open` high without a gap.
- `gate_open` = state is OPEN or PASSING. `alarm` = state is ALARM.

## Timing
- All outputs are registered.
- Reset values: `gate_open`=0, `grant_ack`=0, `timeout`=0, `alarm`=0, `pass_count`=0, `state`=CLOSED, pending=0, timer=0.
- Latency: `code` change to `grant_ack`/`gate_open` high = 1 cycle (the edge that samples the grant).
- Open window: with no beam, `gate_open` is high exactly OPEN_TICKS cycles. `timeout` is high in the cycle after the last open cycle, alongside `gate_open`=0.
- Grant edge and `beam`=1 in the same CLOSED cycle: the grant wins → OPEN. `beam` still high on the next cycle → PASSING, with no alarm.
- `beam` rising on the same cycle as the OPEN timer expiry: the beam wins → PASSING.
- Reset mid-passage: next cycle is CLOSED, the count is cleared and no increment occurs.

## Configuration
- `TURNSTILE_ALARM_EN` defined:
  - ALARM state is implemented.
  - `beam` in CLOSED raises `alarm`.
- Undefined:
  - ALARM is unreachable and `alarm` is tied 0.
  - `beam` in CLOSED is ignored.
  - Grants while not CLOSED still use pending.

## Test plan
- Reset, then `code` 0→1 held 20 cycles, `beam` low (OPEN_TICKS=8) → one `grant_ack`, `gate_open` high 8 cycles, one `timeout`, `pass_count`=0.
- Grant, then `beam` high 3 cycles starting 2 cycles after grant → CLOSED the cycle after beam falls, `pass_count`=1.
- Two grant edges (1→0→1) during one passage → second ack, gate reopens immediately after the first passage, second passage gives `pass_count`=2; a third edge while pending gives no ack.
- `TURNSTILE_ALARM_EN` on, `beam` high 1 cycle in CLOSED → `alarm` high 4 cycles (ALARM_TICKS=4), then CLOSED. Macro off: `alarm` stays 0.
- `CNT_W`=8 preloaded to 255 via 255 passages, one more → `pass_count`=0. `code` held at 1 across reset → no grant after reset.

Source files
------------

// File: rtl/turnstile_gate.sv
// turnstile_gate: gate-side controller for the fare validator status code.
// Converts each fresh FARE_OK code edge into one barrier opening. It supervises
// the passage beam, closes on completed passage or timeout, and counts passengers.
// Optional feature macro: TURNSTILE_ALARM_EN enables the forced-entry ALARM state.
module turnstile_gate #(
  parameter int unsigned OPEN_TICKS  = 8,
  parameter int unsigned ALARM_TICKS = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       code,
  input  logic             beam,
  output logic             gate_open,
  output logic             grant_ack,
  output logic             timeout,
  output logic             alarm,
  output logic [CNT_W-1:0] pass_count,
  output logic [1:0]       state
);

  localparam logic [2:0]  FARE_OK   = 3'd1;
  localparam int unsigned MAX_TICKS = (OPEN_TICKS > ALARM_TICKS) ? OPEN_TICKS : ALARM_TICKS;
  // Timer only ever holds 0 .. MAX_TICKS-1.
  localparam int unsigned TMR_W     = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_PASSING = 2'd2,
    ST_ALARM   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               pending_q, pending_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2:0]         code_q;
  logic               ack_d;
  logic               timeout_d;

  logic               grant_edge_c;
  logic               grant_pend_c;
  logic               pending_now_c;

  // Previous code sample; also loaded under reset so a held FARE_OK cannot grant.
  always_ff @(posedge clk) begin
    code_q <= code;
  end

  // Rising into FARE_OK is the only thing that counts as a grant.
  assign grant_edge_c = (code == FARE_OK) && (code_q != FARE_OK);

  // A grant outside CLOSED is queued only when the one-deep pending slot is free.
  assign grant_pend_c  = grant_edge_c && (state_q != ST_CLOSED) && !pending_q;
  assign pending_now_c = pending_q | grant_pend_c;

  // Next-state, timer, pending and counter logic.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_now_c;
    count_d   = count_q;
    ack_d     = grant_pend_c;
    timeout_d = 1'b0;

    case (state_q)
      ST_CLOSED: begin
        if (grant_edge_c) begin
          state_d = ST_OPEN;
          timer_d = '0;
          ack_d   = 1'b1;
        end
`ifdef TURNSTILE_ALARM_EN
        else if (beam) begin
          state_d = ST_ALARM;
          timer_d = '0;
        end
`endif
      end

      ST_OPEN: begin
        if (beam) begin
          state_d = ST_PASSING;
        end else if (timer_q == TMR_W'(OPEN_TICKS - 1)) begin
          timeout_d = 1'b1;
          timer_d   = '0;
          if (pending_now_c) begin
            state_d   = ST_OPEN;
            pending_d = 1'b0;
          end else begin
            state_d = ST_CLOSED;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_PASSING: begin
        if (!beam) begin
          count_d = count_q + CNT_W'(1);
          timer_d = '0;
          if (pending_now_c) begin
            state_d   = ST_OPEN;
            pending_d = 1'b0;
          end else begin
            state_d = ST_CLOSED;
          end
        end
      end

`ifdef TURNSTILE_ALARM_EN
      ST_ALARM: begin
        if ((timer_q >= TMR_W'(ALARM_TICKS - 1)) && !beam) begin
          timer_d = '0;
          if (pending_now_c) begin
            state_d   = ST_OPEN;
            pending_d = 1'b0;
          end else begin
            state_d = ST_CLOSED;
          end
        end else if (timer_q < TMR_W'(ALARM_TICKS - 1)) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
`endif

      default: begin
        state_d   = ST_CLOSED;
        timer_d   = '0;
        pending_d = 1'b0;
      end
    endcase
  end

  // State, bookkeeping and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLOSED;
      timer_q   <= '0;
      pending_q <= 1'b0;
      count_q   <= '0;
      gate_open <= 1'b0;
      grant_ack <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      gate_open <= (state_d == ST_OPEN) || (state_d == ST_PASSING);
      grant_ack <= ack_d;
      timeout   <= timeout_d;
    end
  end

`ifdef TURNSTILE_ALARM_EN
  // Forced-entry indicator follows the ALARM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm <= 1'b0;
    end else begin
      alarm <= (state_d == ST_ALARM);
    end
  end
`else
  assign alarm = 1'b0;
`endif

  assign pass_count = count_q;
  assign state      = state_q;

endmodule
